rng_draw_ctrl: RTL and testbench

Parametrised successor to the single-bit card-request controller in the RNG card path. Accepts a request for N cards, then sequences the random generator through warm-up, step and hand-off states, and presents each card with a valid/ack handshake. It sits between the game/request logic and the LFSR datapath, which it drives via gen_en_o. Its encoded state is exported for debug.

---
 rtl/rng_cp_pkg.sv | 12 +
 rtl/rng_cp_downcnt.sv | 34 +++
 rtl/rng_draw_ctrl.sv | 153 +++++++++++++++
 tb/tb_rng_draw_ctrl.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rng_cp_pkg.sv
// Shared definitions for the RNG card-path draw controller: state encoding
// exported on state_o and the width of that encoding.
package rng_cp_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
    localparam logic [STATE_W-1:0] ST_WARMUP = 2'd1;
    localparam logic [STATE_W-1:0] ST_GEN    = 2'd2;
    localparam logic [STATE_W-1:0] ST_SEND   = 2'd3;

endpackage

// File: rtl/rng_cp_downcnt.sv
// Loadable down-counter with zero and one flags; saturates at zero so it never
// wraps. Used for the warm-up timer and the remaining-cards counter.
module rng_cp_downcnt
    import rng_cp_pkg::*;
#(
    parameter int CNT_W = 4
) (
    input  logic             clk_cp_i,
    input  logic             rst_cp_i,
    input  logic             clr,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             zero,
    output logic             last
);

    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
    assign last = (cnt == CNT_W'(1));

endmodule

// File: rtl/rng_draw_ctrl.sv
// Multi-card draw controller for the RNG card path: warm-up, step and hand-off
// sequencing with a valid/ack handshake. Define RNG_CP_TIMEOUT_EN to add the ack timeout.
module rng_draw_ctrl
    import rng_cp_pkg::*;
#(
    parameter int CNT_W       = 4,
    parameter int WARMUP_CYC  = 8,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk_cp_i,
    input  logic               rst_cp_i,
    input  logic               req_card_i,
    input  logic [CNT_W-1:0]   draw_count_i,
    input  logic               card_ack_i,
    output logic               gen_en_o,
    output logic               card_valid_o,
    output logic               busy_o,
    output logic               done_o,
    output logic               timeout_o,
    output logic [CNT_W-1:0]   remaining_o,
    output logic [STATE_W-1:0] state_o
);

    // Warm-up counter is loaded with WARMUP_CYC-1 so WARMUP spans exactly WARMUP_CYC cycles.
    localparam int WU_W = (WARMUP_CYC > 1) ? $clog2(WARMUP_CYC) : 1;
    localparam logic [WU_W-1:0] WU_LOAD = (WARMUP_CYC > 0) ? WU_W'(WARMUP_CYC - 1) : '0;

    logic [STATE_W-1:0] state_q, state_nxt;
    logic               wu_load, wu_dec, wu_zero, wu_last;
    logic [WU_W-1:0]    wu_cnt;
    logic               rem_load, rem_dec, rem_clr, rem_zero, rem_last;
    logic [CNT_W-1:0]   rem_cnt;
    logic               done_nxt, done_q;
    logic               to_hit;
    logic               unused_wu;

    rng_cp_downcnt #(.CNT_W(WU_W)) u_wu_cnt (
        .clk_cp_i (clk_cp_i),
        .rst_cp_i (rst_cp_i),
        .clr      (1'b0),
        .load     (wu_load),
        .load_val (WU_LOAD),
        .dec      (wu_dec),
        .cnt      (wu_cnt),
        .zero     (wu_zero),
        .last     (wu_last)
    );

    rng_cp_downcnt #(.CNT_W(CNT_W)) u_rem_cnt (
        .clk_cp_i (clk_cp_i),
        .rst_cp_i (rst_cp_i),
        .clr      (rem_clr),
        .load     (rem_load),
        .load_val (draw_count_i),
        .dec      (rem_dec),
        .cnt      (rem_cnt),
        .zero     (rem_zero),
        .last     (rem_last)
    );

    assign unused_wu = ^{wu_cnt, wu_last};

`ifdef RNG_CP_TIMEOUT_EN
    localparam int WT_W = $clog2(TIMEOUT_CYC + 1);

    logic [WT_W-1:0] wait_q;
    logic            to_q;

    // An ack on the timeout edge takes priority, so the hit is qualified by !card_ack_i.
    assign to_hit = (state_q == ST_SEND) && !card_ack_i && (wait_q == WT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            wait_q <= '0;
            to_q   <= 1'b0;
        end else begin
            to_q <= to_hit;
            if (state_q != ST_SEND) begin
                wait_q <= '0;
            end else if (!card_ack_i) begin
                wait_q <= wait_q + 1'b1;
            end
        end
    end

    assign timeout_o = to_q;
`else
    assign to_hit    = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_comb begin
        state_nxt = state_q;
        wu_load   = 1'b0;
        wu_dec    = 1'b0;
        rem_load  = 1'b0;
        rem_dec   = 1'b0;
        rem_clr   = 1'b0;
        done_nxt  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_card_i && (draw_count_i != '0)) begin
                    rem_load  = 1'b1;
                    wu_load   = 1'b1;
                    state_nxt = (WARMUP_CYC > 0) ? ST_WARMUP : ST_GEN;
                end
            end
            ST_WARMUP: begin
                if (wu_zero) begin
                    state_nxt = ST_GEN;
                end else begin
                    wu_dec = 1'b1;
                end
            end
            ST_GEN: begin
                state_nxt = ST_SEND;
            end
            ST_SEND: begin
                if (card_ack_i && !rem_zero) begin
                    rem_dec = 1'b1;
                    if (rem_last) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt = ST_GEN;
                    end
                end else if (to_hit) begin
                    state_nxt = ST_IDLE;
                    rem_clr   = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_cp_i or negedge rst_cp_i) begin
        if (!rst_cp_i) begin
            state_q <= ST_IDLE;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            done_q  <= done_nxt;
        end
    end

    assign gen_en_o     = (state_q == ST_WARMUP) || (state_q == ST_GEN);
    assign card_valid_o = (state_q == ST_SEND);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = done_q;
    assign remaining_o  = rem_cnt;
    assign state_o      = state_q;

endmodule

// File: tb/tb_rng_draw_ctrl.sv
// Bench for rng_draw_ctrl: two instances (8-cycle and zero warm-up) checked cycle by
// cycle against expected timelines built from the request/ack rules.
module tb_rng_draw_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       req8, ack8, req0, ack0;
    logic [3:0] cnt8, cnt0;
    logic       gen8, val8, busy8, done8, to8;
    logic       gen0, val0, busy0, done0, to0;
    logic [3:0] rem8, rem0;
    logic [1:0] st8, st0;

    int tests = 0;
    int fails = 0;

    rng_draw_ctrl #(.CNT_W(4), .WARMUP_CYC(8), .TIMEOUT_CYC(64)) u_dut8 (
        .clk_cp_i(clk), .rst_cp_i(rst_n), .req_card_i(req8), .draw_count_i(cnt8),
        .card_ack_i(ack8), .gen_en_o(gen8), .card_valid_o(val8), .busy_o(busy8),
        .done_o(done8), .timeout_o(to8), .remaining_o(rem8), .state_o(st8));

    rng_draw_ctrl #(.CNT_W(4), .WARMUP_CYC(0), .TIMEOUT_CYC(64)) u_dut0 (
        .clk_cp_i(clk), .rst_cp_i(rst_n), .req_card_i(req0), .draw_count_i(cnt0),
        .card_ack_i(ack0), .gen_en_o(gen0), .card_valid_o(val0), .busy_o(busy0),
        .done_o(done0), .timeout_o(to0), .remaining_o(rem0), .state_o(st0));

    typedef struct {
        logic [1:0] st;
        logic [3:0] rem;
        logic       done;
        logic       to;
        logic       ack;
    } exp_t;

    exp_t q[$];

    function automatic exp_t mk(input logic [1:0] st, input logic [3:0] rem,
                                input logic done, input logic to, input logic ack);
        exp_t e;
        e.st = st; e.rem = rem; e.done = done; e.to = to; e.ack = ack;
        return e;
    endfunction

    // {gen_en, valid, busy, done, timeout, remaining, state}
    function automatic logic [10:0] pack(input exp_t e);
        return {(e.st == 2'd1) || (e.st == 2'd2), e.st == 2'd3, e.st != 2'd0,
                e.done, e.to, e.rem, e.st};
    endfunction

    function automatic logic [10:0] obs(input bit sel);
        return sel ? {gen0, val0, busy0, done0, to0, rem0, st0}
                   : {gen8, val8, busy8, done8, to8, rem8, st8};
    endfunction

    task automatic set_in(input bit sel, input logic r, input logic [3:0] c, input logic a);
        if (sel) begin
            req0 = r; cnt0 = c; ack0 = a; req8 = 1'b0; cnt8 = '0; ack8 = 1'b0;
        end else begin
            req8 = r; cnt8 = c; ack8 = a; req0 = 1'b0; cnt0 = '0; ack0 = 1'b0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        set_in(0, 1'b0, 4'd0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs(0) !== 11'd0) begin
            fails++; $display("FAIL reset_w8: got %b expected %b", obs(0), 11'd0);
        end
        tests++;
        if (obs(1) !== 11'd0) begin
            fails++; $display("FAIL reset_w0: got %b expected %b", obs(1), 11'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
    endtask

    // Each request: random count and per-card ack delays; expected timeline is
    // WARMUP_CYC warm-up cycles, then per card one GEN cycle and delay+1 SEND cycles.
    task automatic test_requests(input bit sel, input int n, input int first_c,
                                 input int first_d, input bit noise);
        int w;
        int c;
        int d[$];
        logic r_n, a_n;
        w = sel ? 0 : 8;
        for (int r = 0; r < n; r++) begin
            c = (r == 0) ? first_c : ((r == n - 1) ? 15 : $urandom_range(1, 4));
            d.delete();
            for (int i = 0; i < c; i++)
                d.push_back((r == 0) ? first_d : $urandom_range(0, 3));
            q.delete();
            for (int i = 0; i < w; i++) q.push_back(mk(2'd1, 4'(c), 1'b0, 1'b0, 1'b0));
            for (int i = 0; i < c; i++) begin
                q.push_back(mk(2'd2, 4'(c - i), 1'b0, 1'b0, 1'b0));
                for (int j = 0; j <= d[i]; j++)
                    q.push_back(mk(2'd3, 4'(c - i), 1'b0, 1'b0, j == d[i]));
            end
            q.push_back(mk(2'd0, 4'd0, 1'b1, 1'b0, 1'b0));
            q.push_back(mk(2'd0, 4'd0, 1'b0, 1'b0, 1'b0));

            set_in(sel, 1'b1, 4'(c), 1'b0);
            tick();
            foreach (q[k]) begin
                tests++;
                if (obs(sel) !== pack(q[k])) begin
                    fails++;
                    $display("FAIL req_seq w%0d req%0d cyc%0d: got %b expected %b",
                             w, r, k, obs(sel), pack(q[k]));
                end
                r_n = noise && (q[k].st != 2'd0) && ($urandom_range(0, 1) == 1);
                a_n = q[k].ack | (noise && (q[k].st != 2'd3) && ($urandom_range(0, 1) == 1));
                set_in(sel, r_n, 4'($urandom), a_n);
                tick();
            end
            set_in(sel, 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic test_ignore_zero();
        for (int s = 0; s < 2; s++) begin
            set_in(s[0], 1'b1, 4'd0, 1'b1);
            tick();
            tick();
            tests++;
            if (obs(s[0]) !== 11'd0) begin
                fails++; $display("FAIL zero_count dut%0d: got %b expected %b", s, obs(s[0]), 11'd0);
            end
            set_in(s[0], 1'b0, 4'd0, 1'b0);
        end
    endtask

    task automatic test_hold();
        exp_t e;
        set_in(0, 1'b1, 4'd1, 1'b0);
        tick();
        set_in(0, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            e = mk((i < 8) ? 2'd1 : 2'd2, 4'd1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs(0) !== pack(e)) begin
                fails++; $display("FAIL hold_warm cyc%0d: got %b expected %b", i, obs(0), pack(e));
            end
            tick();
        end
        for (int i = 0; i < 21; i++) begin
            e = mk(2'd3, 4'd1, 1'b0, 1'b0, 1'b0);
            tests++;
            if (obs(0) !== pack(e)) begin
                fails++; $display("FAIL hold_send cyc%0d: got %b expected %b", i, obs(0), pack(e));
            end
            set_in(0, 1'b0, 4'd0, i == 20);
            tick();
        end
        set_in(0, 1'b0, 4'd0, 1'b0);
        e = mk(2'd0, 4'd0, 1'b1, 1'b0, 1'b0);
        tests++;
        if (obs(0) !== pack(e)) begin
            fails++; $display("FAIL hold_done: got %b expected %b", obs(0), pack(e));
        end
        tick();
    endtask

    task automatic test_reset_mid();
        int k;
        set_in(0, 1'b1, 4'd3, 1'b0);
        tick();
        set_in(0, 1'b0, 4'd0, 1'b0);
        k = 0;
        while (!val8 && k < 20) begin tick(); k++; end
        tests++;
        if (val8 !== 1'b1) begin
            fails++; $display("FAIL rstmid_first_valid: got %b expected 1", val8);
        end
        set_in(0, 1'b0, 4'd0, 1'b1);
        tick();
        set_in(0, 1'b0, 4'd0, 1'b0);
        k = 0;
        while (!val8 && k < 20) begin tick(); k++; end
        tests++;
        if ({val8, rem8} !== {1'b1, 4'd2}) begin
            fails++; $display("FAIL rstmid_second_card: got %b expected %b", {val8, rem8}, {1'b1, 4'd2});
        end
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if (obs(0) !== 11'd0) begin
            fails++; $display("FAIL rstmid_async: got %b expected %b", obs(0), 11'd0);
        end
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (obs(0) !== 11'd0) begin
                fails++; $display("FAIL rstmid_after cyc%0d: got %b expected %b", i, obs(0), 11'd0);
            end
        end
    endtask

`ifdef RNG_CP_TIMEOUT_EN
    // No ack: 64 SEND cycles then IDLE with a timeout pulse; ack in the 64th cycle wins.
    task automatic test_timeout(input bit ack_last);
        exp_t e;
        set_in(0, 1'b1, ack_last ? 4'd1 : 4'd2, 1'b0);
        tick();
        set_in(0, 1'b0, 4'd0, 1'b0);
        repeat (9) tick();
        for (int i = 0; i < 64; i++) begin
            tests++;
            if ({val8, st8} !== {1'b1, 2'd3}) begin
                fails++; $display("FAIL to_send ack%0d cyc%0d: got %b expected %b", ack_last, i, {val8, st8}, {1'b1, 2'd3});
            end
            set_in(0, 1'b0, 4'd0, ack_last && (i == 63));
            tick();
        end
        set_in(0, 1'b0, 4'd0, 1'b0);
        e = ack_last ? mk(2'd0, 4'd0, 1'b1, 1'b0, 1'b0) : mk(2'd0, 4'd0, 1'b0, 1'b1, 1'b0);
        tests++;
        if (obs(0) !== pack(e)) begin
            fails++; $display("FAIL to_end ack%0d: got %b expected %b", ack_last, obs(0), pack(e));
        end
        tick();
        tests++;
        if (obs(0) !== 11'd0) begin
            fails++; $display("FAIL to_pulse_end ack%0d: got %b expected %b", ack_last, obs(0), 11'd0);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_requests(0, 4, 3, 1, 1'b0);
        test_requests(1, 4, 1, 0, 1'b0);
        test_requests(0, 3, 2, 0, 1'b1);
        test_requests(1, 3, 3, 2, 1'b1);
        test_ignore_zero();
        test_hold();
        test_reset_mid();
`ifdef RNG_CP_TIMEOUT_EN
        test_timeout(1'b0);
        test_timeout(1'b1);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests);
        $fatal(1, "watchdog");
    end

endmodule
